// File: rtl/preif_fetch_ctrl.sv
`default_nettype none
// ==========================================================================
// preif_fetch_ctrl : pre-IF fetch PC select and icache request handshake.
// Optional feature macro: PREIF_DUAL_FETCH_EN (aligned two-slot fetch). Rev 1.0
// ==========================================================================
module preif_fetch_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_entry_i,
  input  logic        ertn_flush_i,
  input  logic [31:0] era_i,
  input  logic        br_redirect_i,
  input  logic [31:0] br_target_i,
  input  logic        if_allowin_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  output logic        to_if_valid_o,
  output logic [31:0] to_if_pc_o,
  output logic [1:0]  to_if_mask_o,
  output logic        to_if_adef_o,
  output logic        drop_data_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_BLOCK = 2'd2
  } state_t;

  localparam logic [1:0] c_max_out = 2'(MAX_OUTSTANDING);

  state_t      r_state, w_state_next;
  logic        r_run;
  logic        r_stop, w_stop_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_buf_valid, w_buf_valid_next;
  logic [31:0] r_buf_pc, w_buf_pc_next;
  logic [1:0]  r_buf_mask, w_buf_mask_next;
  logic        r_buf_adef, w_buf_adef_next;
  logic        r_pend_valid, w_pend_valid_next;
  logic [31:0] r_pend_pc, w_pend_pc_next;
  logic [1:0]  r_out, w_out_next;
  logic [1:0]  r_drop, w_drop_next;

  logic        w_redir;
  logic [31:0] w_redir_pc;
  logic        w_misalign, w_slot_open, w_req, w_adef_go, w_acc, w_ret;
  logic [31:0] w_seq_pc;
  logic [1:0]  w_seq_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_run        <= 1'b0;
      r_stop       <= 1'b0;
      r_pc         <= RESET_PC;
      r_buf_valid  <= 1'b0;
      r_buf_pc     <= 32'd0;
      r_buf_mask   <= 2'b00;
      r_buf_adef   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'd0;
      r_out        <= 2'd0;
      r_drop       <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_run        <= 1'b1;
      r_stop       <= w_stop_next;
      r_pc         <= w_pc_next;
      r_buf_valid  <= w_buf_valid_next;
      r_buf_pc     <= w_buf_pc_next;
      r_buf_mask   <= w_buf_mask_next;
      r_buf_adef   <= w_buf_adef_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_pc    <= w_pend_pc_next;
      r_out        <= w_out_next;
      r_drop       <= w_drop_next;
    end
  end

  always_comb begin
    w_redir    = excep_flush_i | ertn_flush_i | br_redirect_i;
    w_redir_pc = excep_flush_i ? excep_entry_i :
                 ertn_flush_i  ? era_i         : br_target_i;

    w_misalign  = (r_pc[1:0] != 2'b00);
    // HOLD may issue only in the cycle its buffered bundle is consumed
    w_slot_open = (r_state == S_REQ) || ((r_state == S_HOLD) && if_allowin_i);
    w_req       = r_run && !r_stop && !w_misalign && w_slot_open;
    w_adef_go   = r_run && !r_stop &&  w_misalign && w_slot_open;
    w_acc       = w_req && inst_addr_ok_i;
    w_ret       = inst_data_ok_i && (r_out != 2'd0);
    w_out_next  = r_out + 2'(w_acc) - 2'(w_ret);

`ifdef PREIF_DUAL_FETCH_EN
    if (r_pc[2]) begin
      w_seq_pc   = r_pc + 32'd4;
      w_seq_mask = 2'b01;
    end else begin
      w_seq_pc   = r_pc + 32'd8;
      w_seq_mask = 2'b11;
    end
`else
    w_seq_pc   = r_pc + 32'd4;
    w_seq_mask = 2'b01;
`endif

    w_stop_next       = r_stop;
    w_pc_next         = r_pc;
    w_buf_valid_next  = r_buf_valid && !if_allowin_i;
    w_buf_pc_next     = r_buf_pc;
    w_buf_mask_next   = r_buf_mask;
    w_buf_adef_next   = r_buf_adef;
    w_pend_valid_next = r_pend_valid;
    w_pend_pc_next    = r_pend_pc;
    w_drop_next       = (inst_data_ok_i && (r_drop != 2'd0)) ? r_drop - 2'd1 : r_drop;

    if (w_redir) begin
      // every response still in flight belongs to the squashed path
      w_buf_valid_next = 1'b0;
      w_drop_next      = w_out_next;
      w_stop_next      = 1'b0;
      if (w_req && !inst_addr_ok_i) begin
        w_pend_valid_next = 1'b1;
        w_pend_pc_next    = w_redir_pc;
      end else begin
        w_pc_next         = w_redir_pc;
        w_pend_valid_next = 1'b0;
      end
    end else if (w_acc) begin
      if (r_pend_valid) begin
        w_pc_next         = r_pend_pc;
        w_pend_valid_next = 1'b0;
        w_buf_valid_next  = 1'b0;
        w_drop_next       = w_out_next;
      end else begin
        w_buf_valid_next = 1'b1;
        w_buf_pc_next    = r_pc;
        w_buf_mask_next  = w_seq_mask;
        w_buf_adef_next  = 1'b0;
        w_pc_next        = w_seq_pc;
      end
    end else if (w_adef_go) begin
      w_buf_valid_next = 1'b1;
      w_buf_pc_next    = r_pc;
      w_buf_mask_next  = 2'b01;
      w_buf_adef_next  = 1'b1;
      w_stop_next      = 1'b1;
    end

    if (w_out_next == c_max_out) begin
      w_state_next = S_BLOCK;
    end else if (w_buf_valid_next) begin
      w_state_next = S_HOLD;
    end else begin
      w_state_next = S_REQ;
    end
  end

  assign inst_req_o    = w_req;
  assign inst_addr_o   = r_pc;
  assign to_if_valid_o = r_buf_valid;
  assign to_if_pc_o    = r_buf_pc;
  assign to_if_mask_o  = r_buf_mask;
  assign to_if_adef_o  = r_buf_adef;
  assign drop_data_o   = inst_data_ok_i && (r_drop != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_preif_fetch_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_preif_fetch_ctrl : vector table plus response scoreboard for the
// pre-IF fetch controller. Rev 1.0
// ==========================================================================
module tb_preif_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        excep_flush_i = 1'b0;
  logic [31:0] excep_entry_i = 32'd0;
  logic        ertn_flush_i = 1'b0;
  logic [31:0] era_i = 32'd0;
  logic        br_redirect_i = 1'b0;
  logic [31:0] br_target_i = 32'd0;
  logic        if_allowin_i = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic        to_if_valid_o;
  logic [31:0] to_if_pc_o;
  logic [1:0]  to_if_mask_o;
  logic        to_if_adef_o;
  logic        drop_data_o;

  localparam logic [31:0] c_reset_pc = 32'h1C00_0000;

  always #5 clk = ~clk;

  preif_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .excep_flush_i  (excep_flush_i),
    .excep_entry_i  (excep_entry_i),
    .ertn_flush_i   (ertn_flush_i),
    .era_i          (era_i),
    .br_redirect_i  (br_redirect_i),
    .br_target_i    (br_target_i),
    .if_allowin_i   (if_allowin_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .to_if_valid_o  (to_if_valid_o),
    .to_if_pc_o     (to_if_pc_o),
    .to_if_mask_o   (to_if_mask_o),
    .to_if_adef_o   (to_if_adef_o),
    .drop_data_o    (drop_data_o)
  );

  typedef struct {
    logic        rst, chk, full;
    logic        exc, ert, br;
    logic [31:0] ent, era, brt;
    logic        aok, dok, alw;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [1:0]  e_mask;
    logic        e_adef;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   sb_q[$];
  bit   pend = 1'b0;
  vec_t tbl[$];

  function automatic logic [31:0] np(input logic [31:0] pc);
`ifdef PREIF_DUAL_FETCH_EN
    return pc[2] ? pc + 32'd4 : pc + 32'd8;
`else
    return pc + 32'd4;
`endif
  endfunction

  function automatic logic [1:0] nm(input logic [31:0] pc);
`ifdef PREIF_DUAL_FETCH_EN
    return pc[2] ? 2'b01 : 2'b11;
`else
    return 2'b01;
`endif
  endfunction

  function automatic vec_t V(input logic aok, dok, alw, e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = 1'b0; v.chk = 1'b1; v.full = 1'b0;
    v.exc = 1'b0; v.ert = 1'b0; v.br = 1'b0;
    v.ent = 32'd0; v.era = 32'd0; v.brt = 32'd0;
    v.aok = aok; v.dok = dok; v.alw = alw;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_mask = nm(e_pc); v.e_adef = 1'b0;
    return v;
  endfunction

  function automatic vec_t RV(input logic chk, dok);
    vec_t v;
    v = V(1'b0, dok, 1'b0, 1'b0, c_reset_pc, 1'b0, 32'd0);
    v.rst = 1'b1; v.chk = chk; v.full = 1'b1; v.e_mask = 2'b00;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    bit e_drop;
    rst_n          = !v.rst;
    excep_flush_i  = v.exc;  excep_entry_i = v.ent;
    ertn_flush_i   = v.ert;  era_i         = v.era;
    br_redirect_i  = v.br;   br_target_i   = v.brt;
    inst_addr_ok_i = v.aok;  inst_data_ok_i = v.dok;
    if_allowin_i   = v.alw;
    @(negedge clk);
    if (v.chk) begin
      chk("inst_req", idx, 32'(inst_req_o), 32'(v.e_req));
      chk("inst_addr", idx, inst_addr_o, v.e_addr);
      chk("to_if_valid", idx, 32'(to_if_valid_o), 32'(v.e_valid));
      if (v.e_valid || v.full) begin
        chk("to_if_pc", idx, to_if_pc_o, v.e_pc);
        chk("to_if_mask", idx, 32'(to_if_mask_o), 32'(v.e_mask));
        chk("to_if_adef", idx, 32'(to_if_adef_o), 32'(v.e_adef));
      end
    end
    if (v.dok) begin
      e_drop = 1'b0;
      if (!v.rst && sb_q.size() > 0) e_drop = sb_q.pop_front();
      if (v.chk) chk("drop_data", idx, 32'(drop_data_o), 32'(e_drop));
    end
    // response bookkeeping: a redirect squashes everything in flight
    if (v.rst) begin
      sb_q.delete();
      pend = 1'b0;
    end else begin
      if (v.aok && v.e_req) sb_q.push_back(pend);
      if (v.exc || v.ert || v.br) begin
        pend = v.e_req && !v.aok;
        foreach (sb_q[i]) sb_q[i] = 1'b1;
      end else if (v.aok && v.e_req && pend) begin
        pend = 1'b0;
        foreach (sb_q[i]) sb_q[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, p1, p2, e0, e1, x0, x1, m0, t0;
    a0 = 32'h1C00_0000; a1 = np(a0); a2 = np(a1); a3 = np(a2);
    b0 = 32'h1C00_0104; b1 = np(b0); b2 = np(b1); p1 = np(b2); p2 = np(p1);
    e0 = 32'h1C00_8000; e1 = np(e0);
    x0 = 32'h1C00_A000; x1 = np(x0);
    m0 = 32'h1C00_0002; t0 = 32'h1C00_0300;

    tbl.push_back(RV(1'b0, 1'b0));
    tbl.push_back(RV(1'b1, 1'b1));
    tbl.push_back(V(0,1,1, 0,a0, 0,32'd0));       // released, stale data_ok
    tbl.push_back(V(1,0,1, 1,a0, 0,32'd0));
    tbl.push_back(V(1,1,1, 1,a1, 1,a0));
    tbl.push_back(V(1,1,1, 1,a2, 1,a1));
    tbl.push_back(V(0,1,1, 1,a3, 1,a2));
    tbl.push_back(V(0,0,1, 1,a3, 0,32'd0));
    v = V(0,0,1, 1,a3, 0,32'd0); v.br = 1; v.brt = b0; tbl.push_back(v);
    tbl.push_back(V(0,0,1, 1,a3, 0,32'd0));
    tbl.push_back(V(1,0,1, 1,a3, 0,32'd0));       // pending redirect applied
    tbl.push_back(V(0,1,1, 1,b0, 0,32'd0));
    tbl.push_back(V(1,0,1, 1,b0, 0,32'd0));
    tbl.push_back(V(1,1,1, 1,b1, 1,b0));
    tbl.push_back(V(0,1,1, 1,b2, 1,b1));
    tbl.push_back(V(1,0,1, 1,b2, 0,32'd0));
    tbl.push_back(V(1,0,1, 1,p1, 1,b2));
    v = V(0,0,1, 0,p2, 1,p1); v.exc = 1; v.ent = e0; tbl.push_back(v);
    tbl.push_back(V(0,1,1, 0,e0, 0,32'd0));
    tbl.push_back(V(1,1,1, 1,e0, 0,32'd0));
    tbl.push_back(V(0,1,1, 1,e1, 1,e0));
    v = V(1,0,1, 1,e1, 0,32'd0); v.exc = 1; v.ent = x0; v.br = 1; v.brt = 32'h1C00_0500;
    tbl.push_back(v);
    tbl.push_back(V(0,1,1, 1,x0, 0,32'd0));
    tbl.push_back(V(1,0,0, 1,x0, 0,32'd0));
    for (int k = 0; k < 3; k++) tbl.push_back(V(0,0,0, 0,x1, 1,x0));
    tbl.push_back(V(0,1,1, 1,x1, 1,x0));
    tbl.push_back(V(0,0,1, 1,x1, 0,32'd0));
    v = V(1,0,1, 1,x1, 0,32'd0); v.ert = 1; v.era = m0; tbl.push_back(v);
    tbl.push_back(V(0,1,0, 0,m0, 0,32'd0));
    v = V(0,0,0, 0,m0, 1,m0); v.e_mask = 2'b01; v.e_adef = 1; tbl.push_back(v);
    v = V(0,0,1, 0,m0, 1,m0); v.e_mask = 2'b01; v.e_adef = 1; tbl.push_back(v);
    tbl.push_back(V(0,0,1, 0,m0, 0,32'd0));
    v = V(0,0,1, 0,m0, 0,32'd0); v.ert = 1; v.era = t0; v.br = 1; v.brt = 32'h1C00_0200;
    tbl.push_back(v);
    tbl.push_back(V(0,0,1, 1,t0, 0,32'd0));
    v = V(0,0,1, 1,t0, 0,32'd0); v.br = 1; v.brt = 32'h1C00_0400; tbl.push_back(v);
    v = V(0,0,1, 1,t0, 0,32'd0); v.exc = 1; v.ent = e0; tbl.push_back(v);
    tbl.push_back(V(1,0,1, 1,t0, 0,32'd0));
    tbl.push_back(V(0,1,1, 1,e0, 0,32'd0));

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset in the middle of traffic, then fill outstanding to the limit
    apply(V(1,0,1, 1,e0, 0,32'd0), 100);
    apply(RV(1'b0, 1'b0), 101);
    apply(RV(1'b1, 1'b1), 102);
    apply(V(0,1,1, 0,a0, 0,32'd0), 103);
    apply(V(1,0,1, 1,a0, 0,32'd0), 104);
    apply(V(1,0,1, 1,a1, 1,a0), 105);
    apply(V(0,0,1, 0,a2, 1,a1), 106);
    apply(V(0,1,1, 0,a2, 0,32'd0), 107);
    apply(V(0,1,1, 1,a2, 0,32'd0), 108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
